// File: rtl/zbt_sram_arbiter.sv
// Round-robin two-master arbiter and command sequencer for the shared ZBT SRAM port.
// Optional read->write bus turnaround stall enabled by defining ZBT_TURNAROUND_EN.
module zbt_sram_arbiter #(
  parameter int unsigned DSIZE      = 36,
  parameter int unsigned ASIZE      = 19,
  parameter int unsigned BWSIZE     = 4,
  parameter int unsigned RD_LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_rw_n,
  input  logic [ASIZE-1:0]  m0_addr,
  input  logic [BWSIZE-1:0] m0_bw_n,
  input  logic [DSIZE-1:0]  m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_rw_n,
  input  logic [ASIZE-1:0]  m1_addr,
  input  logic [BWSIZE-1:0] m1_bw_n,
  input  logic [DSIZE-1:0]  m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DSIZE-1:0]  m_rdata,
  output logic              lb_cen_n,
  output logic              lb_rw_n,
  output logic [ASIZE-1:0]  lb_addr,
  output logic [BWSIZE-1:0] lb_bw_n,
  output logic [DSIZE-1:0]  lb_wdata,
  input  logic [DSIZE-1:0]  lb_rdata
);

`ifdef ZBT_TURNAROUND_EN
  typedef enum logic [1:0] {StIdle, StIssue, StTurn} state_e;
`else
  typedef enum logic [1:0] {StIdle, StIssue} state_e;
`endif

  state_e                state_q, state_d;
  logic                  last_grant_q;
  logic                  issue_id_q;
  logic [RD_LATENCY-1:0] tag_vld_q;
  logic [RD_LATENCY-1:0] tag_id_q;

  logic win0, win1, win_rw_n, stall, gnt;

  always_comb begin
    win0     = m0_req & (~m1_req | last_grant_q);
    win1     = m1_req & (~m0_req | ~last_grant_q);
    win_rw_n = win1 ? m1_rw_n : m0_rw_n;
`ifdef ZBT_TURNAROUND_EN
    // A read on the bus followed by a write needs one idle cycle for the data bus to turn.
    stall    = (state_q == StIssue) & lb_rw_n & (win0 | win1) & ~win_rw_n;
`else
    stall    = 1'b0;
`endif
    gnt      = (win0 | win1) & ~stall & ~reset;
    m0_gnt   = gnt & win0;
    m1_gnt   = gnt & win1;

    state_d = StIdle;
    if (gnt) begin
      state_d = StIssue;
`ifdef ZBT_TURNAROUND_EN
    end else if (stall) begin
      state_d = StTurn;
`endif
    end
  end

  // The FSM is in StIssue exactly when a command sits on lb_*.
  assign lb_cen_n = (state_q != StIssue);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      issue_id_q   <= 1'b0;
      lb_rw_n      <= 1'b1;
      lb_addr      <= '0;
      lb_bw_n      <= '1;
      lb_wdata     <= '0;
    end else begin
      state_q <= state_d;
      if (gnt) begin
        last_grant_q <= win1;
        issue_id_q   <= win1;
        lb_rw_n      <= win_rw_n;
        lb_addr      <= win1 ? m1_addr : m0_addr;
        lb_bw_n      <= win1 ? m1_bw_n : m0_bw_n;
        lb_wdata     <= win1 ? m1_wdata : m0_wdata;
      end else begin
        lb_rw_n <= 1'b1;
        lb_bw_n <= '1;
      end
    end
  end

  // Tag pipeline tracks each issued read until its word arrives on lb_rdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m_rdata   <= '0;
    end else begin
      tag_vld_q[0] <= (state_q == StIssue) & lb_rw_n;
      tag_id_q[0]  <= issue_id_q;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      m0_rvalid <= tag_vld_q[RD_LATENCY-1] & ~tag_id_q[RD_LATENCY-1];
      m1_rvalid <= tag_vld_q[RD_LATENCY-1] & tag_id_q[RD_LATENCY-1];
      if (tag_vld_q[RD_LATENCY-1]) begin
        m_rdata <= lb_rdata;
      end
    end
  end

endmodule

// File: tb/tb_zbt_sram_arbiter.sv
// Randomized bench for zbt_sram_arbiter: per-cycle transaction model of grants, bus commands
// and read returns, plus reset checks. Honours ZBT_TURNAROUND_EN when defined.
module tb_zbt_sram_arbiter;
  localparam int unsigned DSIZE  = 36;
  localparam int unsigned ASIZE  = 19;
  localparam int unsigned BWSIZE = 4;
  localparam int unsigned LAT    = 3;
  localparam int          NCYC   = 3000;
`ifdef ZBT_TURNAROUND_EN
  localparam bit TURN = 1'b1;
`else
  localparam bit TURN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              m0_req, m0_rw_n, m1_req, m1_rw_n;
  logic [ASIZE-1:0]  m0_addr, m1_addr;
  logic [BWSIZE-1:0] m0_bw_n, m1_bw_n;
  logic [DSIZE-1:0]  m0_wdata, m1_wdata;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DSIZE-1:0]  m_rdata, lb_wdata, lb_rdata;
  logic              lb_cen_n, lb_rw_n;
  logic [ASIZE-1:0]  lb_addr;
  logic [BWSIZE-1:0] lb_bw_n;

  always #5 clk = ~clk;

  zbt_sram_arbiter #(.DSIZE(DSIZE), .ASIZE(ASIZE), .BWSIZE(BWSIZE), .RD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_rw_n(m0_rw_n), .m0_addr(m0_addr), .m0_bw_n(m0_bw_n),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_rw_n(m1_rw_n), .m1_addr(m1_addr), .m1_bw_n(m1_bw_n),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m_rdata(m_rdata), .lb_cen_n(lb_cen_n), .lb_rw_n(lb_rw_n), .lb_addr(lb_addr),
    .lb_bw_n(lb_bw_n), .lb_wdata(lb_wdata), .lb_rdata(lb_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " lb_cen_n"}, 64'(lb_cen_n), 64'd1);
    check_eq({tag, " lb_rw_n"}, 64'(lb_rw_n), 64'd1);
    check_eq({tag, " lb_addr"}, 64'(lb_addr), 64'd0);
    check_eq({tag, " lb_bw_n"}, 64'(lb_bw_n), 64'hF);
    check_eq({tag, " lb_wdata"}, 64'(lb_wdata), 64'd0);
    check_eq({tag, " gnt"}, {62'd0, m1_gnt, m0_gnt}, 64'd0);
    check_eq({tag, " rvalid"}, {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
    check_eq({tag, " m_rdata"}, 64'(m_rdata), 64'd0);
  endtask

  // Master-side command state
  bit                pend[2], granted[2], c_rw[2];
  logic [ASIZE-1:0]  c_addr[2];
  logic [BWSIZE-1:0] c_bw[2];
  logic [DSIZE-1:0]  c_wd[2];

  // Reference model state
  int                mlast;
  logic              e_cen_n, e_rw_n;
  logic [ASIZE-1:0]  e_addr;
  logic [BWSIZE-1:0] e_bw;
  logic [DSIZE-1:0]  e_wd, e_mdata;
  int                exp_rv[0:NCYC+15];
  logic [DSIZE-1:0]  rd_hist[0:NCYC+15];

  task automatic drive_masters(input bit stop);
    for (int k = 0; k < 2; k++) begin
      if (pend[k] && !granted[k]) begin
        if (stop || $urandom_range(0, 19) == 0) pend[k] = 1'b0;
      end else begin
        pend[k] = 1'b0;
        if (!stop && $urandom_range(0, 9) < 7) begin
          pend[k]   = 1'b1;
          c_rw[k]   = 1'($urandom_range(0, 1));
          c_addr[k] = ASIZE'($urandom());
          c_bw[k]   = BWSIZE'($urandom());
          c_wd[k]   = DSIZE'({$urandom(), $urandom()});
        end
      end
      granted[k] = 1'b0;
    end
    m0_req = pend[0]; m0_rw_n = c_rw[0]; m0_addr = c_addr[0]; m0_bw_n = c_bw[0];
    m0_wdata = c_wd[0];
    m1_req = pend[1]; m1_rw_n = c_rw[1]; m1_addr = c_addr[1]; m1_bw_n = c_bw[1];
    m1_wdata = c_wd[1];
  endtask

  initial begin
    int  w;
    bit  have, g;
    reset = 1'b1;
    m0_req = 0; m0_rw_n = 1; m0_addr = '0; m0_bw_n = '1; m0_wdata = '0;
    m1_req = 0; m1_rw_n = 1; m1_addr = '0; m1_bw_n = '1; m1_wdata = '0;
    lb_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0; granted[k] = 0; c_rw[k] = 1; c_addr[k] = '0; c_bw[k] = '1; c_wd[k] = '0;
    end
    for (int i = 0; i <= NCYC + 15; i++) begin
      exp_rv[i] = 0; rd_hist[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;
    mlast = 1; e_cen_n = 1; e_rw_n = 1; e_addr = '0; e_bw = '1; e_wd = '0; e_mdata = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      drive_masters(cyc >= NCYC - 12);
      lb_rdata = DSIZE'({$urandom(), $urandom()});
      rd_hist[cyc] = lb_rdata;
      @(negedge clk);
      // Arbitration rules: lone requester wins, otherwise the one not granted last.
      have = pend[0] || pend[1];
      w = (pend[0] && pend[1]) ? 1 - mlast : (pend[0] ? 0 : 1);
      g = have && !(TURN && !e_cen_n && e_rw_n && !c_rw[w]);
      check_eq("m0_gnt", 64'(m0_gnt), 64'(g && w == 0));
      check_eq("m1_gnt", 64'(m1_gnt), 64'(g && w == 1));
      check_eq("lb_cen_n", 64'(lb_cen_n), 64'(e_cen_n));
      check_eq("lb_rw_n", 64'(lb_rw_n), 64'(e_rw_n));
      check_eq("lb_addr", 64'(lb_addr), 64'(e_addr));
      check_eq("lb_bw_n", 64'(lb_bw_n), 64'(e_bw));
      check_eq("lb_wdata", 64'(lb_wdata), 64'(e_wd));
      if (exp_rv[cyc] != 0) e_mdata = rd_hist[cyc-1];
      check_eq("m0_rvalid", 64'(m0_rvalid), 64'(exp_rv[cyc] == 1));
      check_eq("m1_rvalid", 64'(m1_rvalid), 64'(exp_rv[cyc] == 2));
      check_eq("m_rdata", 64'(m_rdata), 64'(e_mdata));
      if (g) begin
        mlast = w; granted[w] = 1'b1;
        e_cen_n = 0; e_rw_n = c_rw[w]; e_addr = c_addr[w]; e_bw = c_bw[w]; e_wd = c_wd[w];
        if (c_rw[w]) exp_rv[cyc + int'(LAT) + 2] = w + 1;
      end else begin
        e_cen_n = 1; e_rw_n = 1; e_bw = '1;
      end
      @(posedge clk);
      #1;
    end

    // Reset with three reads in flight: no read may return afterwards.
    m1_req = 0; m0_req = 1; m0_rw_n = 1;
    for (int i = 0; i < 3; i++) begin
      m0_addr = ASIZE'(i + 16);
      @(negedge clk);
      check_eq("rst_seq m0_gnt", 64'(m0_gnt), 64'd1);
      @(posedge clk);
      #1;
    end
    m0_req = 0;
    @(negedge clk);
    check_eq("rst_seq issue_addr", 64'(lb_addr), 64'd18);
    @(posedge clk);
    #1;
    reset = 1'b1; m0_req = 1; m1_req = 1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    reset = 1'b0; m0_req = 0; m1_req = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("post_rst rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
